// File: rtl/seq_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_pkg
// Shared definitions for the parallel-to-serial feeder: FSM state encoding
// and the default word width used by the top and its holding buffer.
// -----------------------------------------------------------------------------
package seq_bit_serializer_pkg;

   localparam int SER_DEFAULT_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ser_state_e;

endpackage : seq_bit_serializer_pkg

// File: rtl/seq_bit_serializer_hold_buf.sv
// -----------------------------------------------------------------------------
// ser_hold_buf
// One-entry valid/ready holding buffer in front of the shift register.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   din, din_valid  incoming word and its qualifier
//   din_ready       high while the entry is empty (pure function of state)
//   dout, full      held word and occupancy flag
//   pop             consumer takes the held word this edge
// -----------------------------------------------------------------------------
module ser_hold_buf
   import seq_bit_serializer_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   input  logic             pop
);

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             full_q, full_d;

   // Accept only when empty and pop only when full, so the two never
   // collide; an arriving word on a pop edge is refused because ready was 0.
   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      if (pop) begin
         full_d = 1'b0;
      end
      if (din_valid && !full_q) begin
         hold_d = din;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
      end
   end

   assign din_ready = !full_q;
   assign dout      = hold_q;
   assign full      = full_q;

endmodule : ser_hold_buf

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Accepts parallel words over valid/ready and shifts them out one bit per
// clock on x. A holding buffer plus the shift register let consecutive words
// stream with no idle gap.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   din, din_valid    parallel word and qualifier
//   din_ready         can accept din this cycle (= !hold_full)
//   x, x_valid        serial bit and qualifier (x = IDLE_BIT when not valid)
//   sof, eof          first / last bit of a word
//   busy              hold buffer full or shifting
// -----------------------------------------------------------------------------
module seq_bit_serializer
   import seq_bit_serializer_pkg::*;
#(
   parameter int   WIDTH     = SER_DEFAULT_WIDTH,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy
);

   localparam int              CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             pop;
   logic [WIDTH-1:0] sr_shifted;

   ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (hold_data),
      .full      (hold_full),
      .pop       (pop)
   );

   // The bit on x is always the end of the register facing the shift
   // direction, so the register shifts away from that end.
   assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, sr_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (hold_full) begin
               pop     = 1'b1;
               sr_d    = hold_data;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (hold_full) begin
                  // Reload directly so the next word follows with no gap.
                  pop  = 1'b1;
                  sr_d = hold_data;
               end else begin
                  sr_d    = sr_shifted;
                  state_d = S_IDLE;
               end
            end else begin
               sr_d  = sr_shifted;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from next-state values.
      x_valid_d = (state_d == S_SHIFT);
      if (state_d == S_SHIFT) begin
         x_d = (MSB_FIRST != 0) ? sr_d[WIDTH-1] : sr_d[0];
      end else begin
         x_d = IDLE_BIT;
      end
      sof_d  = (state_d == S_SHIFT) && (cnt_d == '0);
      eof_d  = (state_d == S_SHIFT) && (cnt_d == LAST);
      // Next-cycle occupancy of the hold buffer, mirrored from its own update.
      busy_d = (hold_full && !pop) || (din_valid && din_ready) ||
               (state_d == S_SHIFT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         x_q       <= IDLE_BIT;
         x_valid_q <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         busy_q    <= busy_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign sof     = sof_q;
   assign eof     = eof_q;
   assign busy    = busy_q;

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Directed bench: dut0 uses defaults (WIDTH=8, MSB first, idle 0); dut1 is
// LSB first with an idle level of 1.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] din0, din1;
   logic       v0, v1;
   logic       rdy0, rdy1;
   logic       x0, x1, xv0, xv1, sof0, sof1, eof0, eof1, busy0, busy1;

   int vectors;
   int miscompares;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
      .x(x0), .x_valid(xv0), .sof(sof0), .eof(eof0), .busy(busy0)
   );

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
      .x(x1), .x_valid(xv1), .sof(sof1), .eof(eof1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] stream;
      logic [7:0]  word;

      vectors     = 0;
      miscompares = 0;
      rst  = 1'b0;
      din0 = '0; din1 = '0; v0 = 1'b0; v1 = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst x0", x0, 1'b0);
      chk("rst xv0", xv0, 1'b0);
      chk("rst sof0", sof0, 1'b0);
      chk("rst eof0", eof0, 1'b0);
      chk("rst busy0", busy0, 1'b0);
      chk("rst rdy0", rdy0, 1'b1);
      chk("rst x1", x1, 1'b1);
      chk("rst xv1", xv1, 1'b0);
      rst = 1'b1;
      tick();

      // ---------------- single word, MSB first ----------------
      word = 8'b1001_0110;
      din0 = 8'h96; v0 = 1'b1;
      tick();                       // accept edge
      v0 = 1'b0;
      chk("single pre xv", xv0, 1'b0);
      chk("single pre busy", busy0, 1'b1);
      chk("single pre rdy", rdy0, 1'b0);
      tick();                       // transfer into shifter
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("single x[%0d]", i), x0, word[7-i]);
         chk($sformatf("single xv[%0d]", i), xv0, 1'b1);
         chk($sformatf("single sof[%0d]", i), sof0, (i == 0));
         chk($sformatf("single eof[%0d]", i), eof0, (i == 7));
         tick();
      end
      chk("single post x", x0, 1'b0);
      chk("single post xv", xv0, 1'b0);
      chk("single post busy", busy0, 1'b0);

      // ---------------- back-to-back 96, A5 ----------------
      stream = 16'b1001_0110_1010_0101;
      din0 = 8'h96; v0 = 1'b1;
      tick();                       // accept 96
      din0 = 8'hA5;
      chk("b2b rdy full", rdy0, 1'b0);
      tick();                       // 96 moves to shifter; A5 refused
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("b2b x[%0d]", k), x0, stream[15-k]);
         chk($sformatf("b2b xv[%0d]", k), xv0, 1'b1);
         chk($sformatf("b2b sof[%0d]", k), sof0, (k == 0 || k == 8));
         chk($sformatf("b2b eof[%0d]", k), eof0, (k == 7 || k == 15));
         chk($sformatf("b2b rdy[%0d]", k), rdy0, !(k >= 1 && k <= 7));
         tick();
         if (k == 0) v0 = 1'b0;
      end
      chk("b2b post xv", xv0, 1'b0);
      chk("b2b post busy", busy0, 1'b0);

      // ---------------- backpressure: FF never accepted ----------------
      stream = {8'h3C, 8'hC3};
      din0 = 8'h3C; v0 = 1'b1;
      tick();                       // accept 3C
      din0 = 8'hC3;
      tick();                       // 3C into shifter
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("bp x[%0d]", k), x0, stream[15-k]);
         chk($sformatf("bp sof[%0d]", k), sof0, (k == 0 || k == 8));
         chk($sformatf("bp rdy[%0d]", k), rdy0, !(k >= 1 && k <= 7));
         if (k == 7) v0 = 1'b0;
         tick();
         if (k == 0) din0 = 8'hFF;  // C3 was taken on this edge
      end
      chk("bp post xv", xv0, 1'b0);
      chk("bp post busy", busy0, 1'b0);

      // ---------------- LSB first on dut1 ----------------
      word = 8'h96;
      din1 = 8'h96; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb x[%0d]", i), x1, word[i]);
         chk($sformatf("lsb sof[%0d]", i), sof1, (i == 0));
         chk($sformatf("lsb eof[%0d]", i), eof1, (i == 7));
         tick();
      end
      chk("lsb post x", x1, 1'b1);
      chk("lsb post xv", xv1, 1'b0);

      // ---------------- reset mid-word ----------------
      din0 = 8'h96; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick(); tick(); tick(); tick(); // three bits shown, fourth on x now
      chk("mid pre xv", xv0, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("mid rst xv", xv0, 1'b0);
      chk("mid rst x", x0, 1'b0);
      chk("mid rst sof", sof0, 1'b0);
      chk("mid rst eof", eof0, 1'b0);
      chk("mid rst busy", busy0, 1'b0);
      chk("mid rst rdy", rdy0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("mid idle xv", xv0, 1'b0);
      word = 8'b0000_1111;
      din0 = 8'h0F; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mid x[%0d]", i), x0, word[7-i]);
         chk($sformatf("mid sof[%0d]", i), sof0, (i == 0));
         tick();
      end
      chk("mid post xv", xv0, 1'b0);

      // ---------------- idle line with IDLE_BIT=1 ----------------
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("idle x[%0d]", i), x1, 1'b1);
         chk($sformatf("idle xv[%0d]", i), xv1, 1'b0);
         chk($sformatf("idle busy[%0d]", i), busy1, 1'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_seq_bit_serializer

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line (x).
- A one-entry holding buffer plus a shift register allow back-to-back words to stream with no idle gap between them.
- x_valid, sof and eof qualify the serial stream for downstream consumers.

Parameters:
- WIDTH, 8, bits per parallel word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0, value driven on x whenever x_valid=0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept din this cycle.
- x  output  1  serial bit stream to the detector.
- x_valid  output  1  x carries a data bit this cycle.
- sof  output  1  x is the first bit of a word.
- eof  output  1  x is the last bit of a word.
- busy  output  1  hold buffer full or shifting in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hold_full=0; bit counter=0; shift register=0.
  - x=IDLE_BIT; x_valid=0; sof=0; eof=0; busy=0; din_ready=1.
- Outputs:
  - All outputs are registered, except din_ready = !hold_full.
  - din_ready depends only on registered state; there is no combinational path from din_valid.
- Accept:
  - On a rising edge with din_valid && din_ready, hold_reg <= din and hold_full <= 1.
  - When din_ready=0, din is ignored; hold_reg is never overwritten while full.
- States: IDLE and SHIFT.
- IDLE:
  - With hold_full=1, the next edge loads the shift register from hold_reg, clears hold_full, sets cnt=0 and moves to SHIFT.
  - Otherwise the block stays in IDLE with x=IDLE_BIT and x_valid=0.
- SHIFT:
  - x = current output bit of the shift register, selected per MSB_FIRST; x_valid=1.
  - sof=1 when cnt==0; eof=1 when cnt==WIDTH-1.
  - At each edge, shift by one and increment cnt.
- End of word (edge where cnt==WIDTH-1):
  - If hold_full=1: reload the shift register from hold_reg, clear hold_full, cnt=0, stay in SHIFT. x_valid stays 1 with no gap and sof rises on the next cycle.
  - If hold_full=0: return to IDLE; x=IDLE_BIT and x_valid=0 from the next cycle.
- Simultaneous transfer and accept:
  - If hold_reg moves into the shifter on the same edge that din_valid is high, din_ready was 0, so no accept occurs.
  - din_ready rises the following cycle.
- Latency: a word accepted at edge N from IDLE drives its first bit (x_valid=1, sof=1) after edge N+1.
- Throughput: one word per WIDTH cycles sustained.
- Counter: width $clog2(WIDTH); no wrap beyond WIDTH-1.
- busy = hold_full | (state==SHIFT).
- Reset mid-word: the in-flight word and the hold buffer are discarded; outputs return to reset values immediately; no partial word resumes.

Decomposition:
- Shared header seq_ser_defs.vh holds:
  - state encodings: localparam S_IDLE=1'b0, S_SHIFT=1'b1;
  - the default WIDTH.
- One natural sub-module: ser_hold_buf, the one-entry valid/ready buffer (din, din_valid, din_ready, dout, full, pop).
- The shift/FSM logic stays in the top module.

Test Plan:
- Single word: WIDTH=8, MSB_FIRST=1, din=8'h96 for one cycle.
  - x = 1,0,0,1,0,1,1,0 on 8 consecutive cycles starting 2 edges after accept.
  - sof on bit 1 only, eof on bit 8 only; then x=0 and x_valid=0.
- Back-to-back: din_valid held high with 8'h96 then 8'hA5.
  - 16 contiguous x_valid cycles: 10010110 then 10100101.
  - sof at cycles 1 and 9, eof at cycles 8 and 16.
  - din_ready low whenever hold_full=1.
- Backpressure: while shifting with hold_full=1, present din=8'hFF with din_valid=1.
  - din_ready=0; 8'hFF is never serialized; the held word is emitted unchanged.
- LSB_FIRST: MSB_FIRST=0, din=8'h96.
  - x = 0,1,1,0,1,0,0,1.
- Reset mid-word: assert rst=0 asynchronously after the 3rd bit of 8'h96 (between clock edges).
  - x_valid, sof, eof and busy go 0 and x=IDLE_BIT immediately; din_ready=1.
  - After release, a new 8'h0F serializes cleanly as 00001111.
- Idle line: IDLE_BIT=1 with no input for 20 cycles.
  - x=1, x_valid=0 and busy=0 throughout.
